// File: rtl/interrupt_scheduler_regs_pkg.sv
// interrupt_scheduler_regs_pkg: register map, response codes, FSM states and strobe merge helper
package interrupt_scheduler_regs_pkg;

    localparam int REG_COUNT = 4;

    localparam logic [1:0] REG0_IDX = 2'd0;
    localparam logic [1:0] REG1_IDX = 2'd1;
    localparam logic [1:0] REG2_IDX = 2'd2;
    localparam logic [1:0] REG3_IDX = 2'd3;

    localparam logic [3:0] REG0_OFFSET = 4'h0;
    localparam logic [3:0] REG1_OFFSET = 4'h4;
    localparam logic [3:0] REG2_OFFSET = 4'h8;
    localparam logic [3:0] REG3_OFFSET = 4'hC;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    typedef enum logic [2:0] {
        W_IDLE,
        W_HAVE_ADDR,
        W_HAVE_DATA,
        W_COMMIT,
        W_RESP
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_RESP
    } rd_state_t;

    function automatic logic [31:0] apply_wstrb(input logic [31:0] old, input logic [31:0] data,
                                                input logic [3:0] strb);
        logic [31:0] merged;
        for (int i = 0; i < 4; i++) merged[8*i +: 8] = strb[i] ? data[8*i +: 8] : old[8*i +: 8];
        return merged;
    endfunction

endpackage

// File: rtl/interrupt_scheduler_s_axi_slave.sv
// interrupt_scheduler_s_axi_slave: AXI4-Lite register slave with four RW registers and write pulses
module interrupt_scheduler_s_axi_slave
    import interrupt_scheduler_regs_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                                         ACLK,
    input  logic                                         ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]                S_AXI_AWADDR,
    input  logic [2:0]                                   S_AXI_AWPROT,
    input  logic                                         S_AXI_AWVALID,
    output logic                                         S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]                S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]              S_AXI_WSTRB,
    input  logic                                         S_AXI_WVALID,
    output logic                                         S_AXI_WREADY,
    output logic [1:0]                                   S_AXI_BRESP,
    output logic                                         S_AXI_BVALID,
    input  logic                                         S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]                S_AXI_ARADDR,
    input  logic [2:0]                                   S_AXI_ARPROT,
    input  logic                                         S_AXI_ARVALID,
    output logic                                         S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]                S_AXI_RDATA,
    output logic [1:0]                                   S_AXI_RRESP,
    output logic                                         S_AXI_RVALID,
    input  logic                                         S_AXI_RREADY,
    output logic [REG_COUNT-1:0][C_S_AXI_DATA_WIDTH-1:0] reg_q,
    output logic [REG_COUNT-1:0]                         reg_wr_pulse
);

    wr_state_t w_state, w_next;
    rd_state_t r_state, r_next;
    logic [1:0] aw_idx;
    logic [C_S_AXI_DATA_WIDTH-1:0] w_data;
    logic [C_S_AXI_DATA_WIDTH/8-1:0] w_strb;
    logic aw_hs, w_hs, ar_hs;
    logic unused_bits;

    assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs = S_AXI_WVALID && S_AXI_WREADY;
    assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;
    assign S_AXI_BRESP = AXI_RESP_OKAY;
    assign S_AXI_RRESP = AXI_RESP_OKAY;
    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // Write FSM next state: collect AW and W in either order, commit once, then hold the response
    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:      w_next = (aw_hs && w_hs) ? W_COMMIT : aw_hs ? W_HAVE_ADDR : w_hs ? W_HAVE_DATA : W_IDLE;
            W_HAVE_ADDR: w_next = w_hs ? W_COMMIT : W_HAVE_ADDR;
            W_HAVE_DATA: w_next = aw_hs ? W_COMMIT : W_HAVE_DATA;
            W_COMMIT:    w_next = W_RESP;
            W_RESP:      w_next = S_AXI_BREADY ? W_IDLE : W_RESP;
            default:     w_next = W_IDLE;
        endcase
    end

    // Read FSM next state: accept an address when idle, hold the data until the master takes it
    always_comb begin
        r_next = (r_state == R_IDLE) ? (ar_hs ? R_RESP : R_IDLE) : (S_AXI_RREADY ? R_IDLE : R_RESP);
    end

    // Write path registers: readies derived from the next state so they never depend on inputs combinationally
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            w_state       <= W_IDLE;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_BVALID  <= 1'b0;
            aw_idx        <= '0;
            w_data        <= '0;
            w_strb        <= '0;
            reg_q         <= '0;
            reg_wr_pulse  <= '0;
        end else begin
            w_state       <= w_next;
            S_AXI_AWREADY <= (w_next == W_IDLE) || (w_next == W_HAVE_DATA);
            S_AXI_WREADY  <= (w_next == W_IDLE) || (w_next == W_HAVE_ADDR);
            S_AXI_BVALID  <= (w_next == W_RESP);
            reg_wr_pulse  <= '0;
            if (aw_hs) aw_idx <= S_AXI_AWADDR[3:2];
            if (w_hs) begin
                w_data <= S_AXI_WDATA;
                w_strb <= S_AXI_WSTRB;
            end
            if (w_state == W_COMMIT) begin
                reg_q[aw_idx]        <= apply_wstrb(reg_q[aw_idx], w_data, w_strb);
                reg_wr_pulse[aw_idx] <= 1'b1;
            end
        end
    end

    // Read path registers: data sampled from the pre-commit register value on the handshake edge
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state       <= R_IDLE;
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RDATA   <= '0;
        end else begin
            r_state       <= r_next;
            S_AXI_ARREADY <= (r_next == R_IDLE);
            S_AXI_RVALID  <= (r_next == R_RESP);
            if (ar_hs) S_AXI_RDATA <= reg_q[S_AXI_ARADDR[3:2]];
        end
    end

endmodule

// File: tb/tb_interrupt_scheduler_s_axi_slave.sv
// tb_interrupt_scheduler_s_axi_slave: vector table, directed corner sequences and random traffic against a register model
module tb_interrupt_scheduler_s_axi_slave;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [3:0] awaddr = '0, araddr = '0;
    logic [2:0] awprot = '0, arprot = '0;
    logic awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic [31:0] wdata = '0;
    logic [3:0] wstrb = '0;
    logic awready, wready, bvalid, arready, rvalid;
    logic [1:0] bresp, rresp;
    logic [31:0] rdata;
    logic [3:0][31:0] reg_q;
    logic [3:0] reg_wr_pulse;

    int checks = 0;
    int errors = 0;
    int pulse_cnt [4] = '{0, 0, 0, 0};
    logic [31:0] model [4] = '{0, 0, 0, 0};

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [9] = '{
        '{4'h0, 32'h0000_0001, 4'hF, 32'h0000_0001},
        '{4'h4, 32'h0000_0002, 4'hF, 32'h0000_0002},
        '{4'h8, 32'h0000_0003, 4'hF, 32'h0000_0003},
        '{4'hC, 32'h0000_0004, 4'hF, 32'h0000_0004},
        '{4'h4, 32'hAABB_CCDD, 4'hF, 32'hAABB_CCDD},
        '{4'h4, 32'h1122_3344, 4'h5, 32'hAA22_CC44},
        '{4'h8, 32'hFFFF_FFFF, 4'h0, 32'h0000_0003},
        '{4'hE, 32'h1234_5678, 4'h8, 32'h1200_0004},
        '{4'h1, 32'hCAFE_BABE, 4'h3, 32'h0000_BABE}
    };

    interrupt_scheduler_s_axi_slave dut (
        .ACLK(clk), .ARESET(rst),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .reg_q(reg_q), .reg_wr_pulse(reg_wr_pulse)
    );

    always #5 clk = ~clk;

    // Count high cycles of each write pulse, sampled mid-cycle
    always @(negedge clk) for (int i = 0; i < 4; i++) if (reg_wr_pulse[i]) pulse_cnt[i]++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        for (int b = 0; b < 4; b++) if (s[b]) model[a[3:2]][8*b +: 8] = d[8*b +: 8];
    endfunction

    task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int ad, input int wd);
        bit aw_done = 0, w_done = 0, aw_hs, w_hs;
        int n = 0, total0 = 0, total1 = 0, idx_before;
        idx_before = pulse_cnt[a[3:2]];
        for (int i = 0; i < 4; i++) total0 += pulse_cnt[i];
        awaddr = a; wdata = d; wstrb = s;
        while (!(aw_done && w_done) && n < 60) begin
            awvalid = !aw_done && n >= ad;
            wvalid = !w_done && n >= wd;
            aw_hs = awvalid && awready;
            w_hs = wvalid && wready;
            step();
            aw_done |= aw_hs;
            w_done |= w_hs;
            n++;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        check("write_handshakes", {31'b0, aw_done && w_done}, 32'd1);
        model_write(a, d, s);
        bready = 1'b1;
        n = 0;
        while (!bvalid && n < 20) begin step(); n++; end
        check("bvalid", {31'b0, bvalid}, 32'd1);
        check("bresp", {30'b0, bresp}, 32'd0);
        step();
        bready = 1'b0;
        for (int i = 0; i < 4; i++) total1 += pulse_cnt[i];
        check("wr_pulse_idx", pulse_cnt[a[3:2]] - idx_before, 32'd1);
        check("wr_pulse_total", total1 - total0, 32'd1);
    endtask

    task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
        bit done = 0, hs;
        int n = 0;
        araddr = a; arvalid = 1'b1;
        while (!done && n < 60) begin hs = arready; step(); done = hs; n++; end
        arvalid = 1'b0;
        check("read_handshake", {31'b0, done}, 32'd1);
        n = 0;
        while (!rvalid && n < 20) begin step(); n++; end
        check("rvalid", {31'b0, rvalid}, 32'd1);
        check("rresp", {30'b0, rresp}, 32'd0);
        d = rdata;
        rready = 1'b1;
        step();
        rready = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic [3:0] a;
        // reset state
        repeat (3) step();
        check("rst_awready", {31'b0, awready}, 32'd0);
        check("rst_wready", {31'b0, wready}, 32'd0);
        check("rst_arready", {31'b0, arready}, 32'd0);
        check("rst_valids", {30'b0, bvalid, rvalid}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        for (int i = 0; i < 4; i++) check("rst_reg_q", reg_q[i], 32'd0);
        rst = 1'b0;
        step();
        check("post_rst_readies", {29'b0, awready, wready, arready}, 32'd7);

        // vector table
        foreach (vecs[i]) begin
            axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, 0, 0);
            axi_read(vecs[i].addr, rd);
            check($sformatf("vec%0d_read", i), rd, vecs[i].exp);
            check($sformatf("vec%0d_reg_q", i), reg_q[vecs[i].addr[3:2]], vecs[i].exp);
        end

        // W three cycles before AW
        wdata = 32'h0BAD_F00D; wstrb = 4'hF; wvalid = 1'b1;
        step();
        wvalid = 1'b0;
        check("wfirst_wready_low", {31'b0, wready}, 32'd0);
        repeat (3) begin
            check("wfirst_awready_high", {31'b0, awready}, 32'd1);
            check("wfirst_no_bvalid", {31'b0, bvalid}, 32'd0);
            step();
        end
        awaddr = 4'h8; awvalid = 1'b1;
        step();
        awvalid = 1'b0;
        check("wfirst_not_yet", reg_q[2], model[2]);
        step();
        model_write(4'h8, 32'h0BAD_F00D, 4'hF);
        check("wfirst_bvalid", {31'b0, bvalid}, 32'd1);
        check("wfirst_reg", reg_q[2], 32'h0BAD_F00D);
        check("wfirst_pulse", {28'b0, reg_wr_pulse}, 32'h4);
        bready = 1'b1; step(); bready = 1'b0;

        // BREADY held low for 10 cycles with a second AW waiting
        awaddr = 4'hC; wdata = 32'hDEAD_BEEF; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        step();
        wvalid = 1'b0; awaddr = 4'h0;
        step();
        model_write(4'hC, 32'hDEAD_BEEF, 4'hF);
        repeat (10) begin
            check("bhold_bvalid", {31'b0, bvalid}, 32'd1);
            check("bhold_readies", {30'b0, awready, wready}, 32'd0);
            step();
        end
        check("bhold_reg", reg_q[3], 32'hDEAD_BEEF);
        bready = 1'b1;
        step();
        bready = 1'b0;
        check("bhold_released", {30'b0, bvalid, awready}, 32'd1);
        step();
        awvalid = 1'b0;
        check("bhold_aw_taken", {31'b0, awready}, 32'd0);
        wdata = 32'h0000_0055; wvalid = 1'b1;
        step();
        wvalid = 1'b0;
        step();
        model_write(4'h0, 32'h0000_0055, 4'hF);
        check("bhold_second_bvalid", {31'b0, bvalid}, 32'd1);
        check("bhold_second_reg", reg_q[0], 32'h0000_0055);
        bready = 1'b1; step(); bready = 1'b0;

        // read and write commit to the same register on the same edge
        axi_write(4'h8, 32'h5, 4'hF, 0, 0);
        awaddr = 4'h8; wdata = 32'h9; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        step();
        awvalid = 1'b0; wvalid = 1'b0; araddr = 4'h8; arvalid = 1'b1;
        step();
        arvalid = 1'b0;
        model_write(4'h8, 32'h9, 4'hF);
        check("same_edge_rvalid", {31'b0, rvalid}, 32'd1);
        check("same_edge_rdata", rdata, 32'h5);
        check("same_edge_reg", reg_q[2], 32'h9);
        rready = 1'b1; bready = 1'b1; step(); rready = 1'b0; bready = 1'b0;
        axi_read(4'h8, rd);
        check("same_edge_reread", rd, 32'h9);

        // reset after AW handshake, before W
        awaddr = 4'h4; awvalid = 1'b1;
        step();
        awvalid = 1'b0; rst = 1'b1;
        step();
        check("midrst_readies", {29'b0, awready, wready, arready}, 32'd0);
        check("midrst_valids", {30'b0, bvalid, rvalid}, 32'd0);
        check("midrst_rdata", rdata, 32'd0);
        for (int i = 0; i < 4; i++) check("midrst_reg_q", reg_q[i], 32'd0);
        for (int i = 0; i < 4; i++) model[i] = '0;
        rst = 1'b0;
        step();
        wdata = 32'h77; wstrb = 4'hF; wvalid = 1'b1;
        step();
        wvalid = 1'b0;
        repeat (3) begin
            check("midrst_w_only_no_b", {31'b0, bvalid}, 32'd0);
            step();
        end
        check("midrst_w_only_reg", reg_q[1], 32'd0);
        check("midrst_w_only_pulse", {28'b0, reg_wr_pulse}, 32'd0);
        awaddr = 4'h4; awvalid = 1'b1;
        step();
        awvalid = 1'b0;
        step();
        model_write(4'h4, 32'h77, 4'hF);
        check("midrst_full_bvalid", {31'b0, bvalid}, 32'd1);
        check("midrst_full_reg", reg_q[1], 32'h77);
        bready = 1'b1; step(); bready = 1'b0;

        // random traffic against the model
        for (int k = 0; k < 40; k++) begin
            a = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1)
                axi_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3));
            else begin
                axi_read(a, rd);
                check($sformatf("rand%0d_read", k), rd, model[a[3:2]]);
            end
        end
        for (int i = 0; i < 4; i++) check("final_reg_q", reg_q[i], model[i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
